uart_rx: RTL and testbench

- Serial receiver, 8N1 by default, directly downstream of the 16x oversampling baud tick generator.
- Consumes the one-cycle `tick` strobe (9600 baud × 16 at 50 MHz), samples the asynchronous `rx` line mid-bit and deserialises LSB first.
- Presents each received byte in a holding register with a valid/read handshake, plus framing and overrun error flags, to the command-decode logic.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_sync.sv | 19 +
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and
// default frame geometry, also intended for the companion transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned MID_START       = 7;
  localparam int unsigned DBIT_DEFAULT    = 8;
  localparam int unsigned SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Byte hand-off between the UART receiver (master) and its consumer (slave):
// holding register, valid/read handshake, end-of-frame pulse and error flags.
interface uart_rx_if #(
  parameter int unsigned DBIT = uart_pkg::DBIT_DEFAULT
);
  logic            rd_en;
  logic [DBIT-1:0] rx_data;
  logic            rx_valid;
  logic            rx_done_tick;
  logic            frame_err;
  logic            overrun_err;

  modport master (
    input  rd_en,
    output rx_data, rx_valid, rx_done_tick, frame_err, overrun_err
  );

  modport slave (
    output rd_en,
    input  rx_data, rx_valid, rx_done_tick, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; presets to the idle
// (high) level on reset so no false start bit is seen when reset releases.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: mid-bit sampling, LSB-first deserialisation,
// holding register with valid/read handshake and sticky framing/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEFAULT,
  parameter int unsigned SB_TICK = SB_TICK_DEFAULT
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       rx,
  input  logic       tick,
  uart_rx_if.master  bus
);
  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            oerr_q, oerr_d;
  logic            done;
  logic            rx_s;

  uart_rx_sync u_sync (
    .clk   (clk_50MHz),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    oerr_d  = oerr_q;
    done    = 1'b0;

    if (bus.rd_en && valid_q) begin
      valid_d = 1'b0;
      oerr_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == SW'(MID_START)) begin
            state_d = rx_s ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else                      n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            // Gated by reset so a tick arriving during reset never pulses.
            done    = reset;
            if (rx_s) begin
              ferr_d = 1'b0;
              if (valid_q && !bus.rd_en) begin
                oerr_d = 1'b1;
              end else begin
                data_d  = b_q;
                valid_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_done_tick = done;
  assign bus.frame_err    = ferr_q;
  assign bus.overrun_err  = oerr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model (done-pulse tick number plus
// holding-register/flag rules) compared against the DUT on every cycle.
module tb_uart_rx;
  localparam int unsigned DB = 8;
  localparam int unsigned SB = 16;
  localparam int unsigned TP = 5;
  localparam int unsigned FRAME_TICKS = 8 + 16 * DB + SB;

  typedef struct {
    int unsigned done_t;
    bit          good;
    logic [7:0]  data;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic tick = 1'b0;

  uart_rx_if #(.DBIT(DB)) bus ();

  uart_rx #(.DBIT(DB), .SB_TICK(SB)) dut (
    .clk_50MHz (clk),
    .reset     (reset),
    .rx        (rx),
    .tick      (tick),
    .bus       (bus.master)
  );

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned tnum = 0;
  int unsigned cyc = 0;
  int unsigned pulses = 0;
  bit check_en = 1'b0;
  bit rand_rd = 1'b0;

  frame_t     q[$];
  logic [7:0] exp_data = '0;
  logic       exp_valid = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_oerr = 1'b0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    tick = (cyc % TP == 0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rd) bus.rd_en = ($urandom_range(0, 7) == 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic       e_done;
    logic [7:0] nd;
    logic       nv, nf, no;
    frame_t     f;
    if (tick) tnum++;
    e_done = reset && tick && (q.size() != 0) && (q[0].done_t == tnum);
    if (check_en) begin
      chk("done_tick", bus.rx_done_tick, e_done);
      chk("rx_data", bus.rx_data, exp_data);
      chk("rx_valid", bus.rx_valid, exp_valid);
      chk("frame_err", bus.frame_err, exp_ferr);
      chk("overrun_err", bus.overrun_err, exp_oerr);
    end
    if (bus.rx_done_tick === 1'b1) pulses++;
    if (!reset) begin
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_oerr  = 1'b0;
      q.delete();
    end else begin
      nd = exp_data; nv = exp_valid; nf = exp_ferr; no = exp_oerr;
      if (bus.rd_en && exp_valid) begin
        nv = 1'b0;
        no = 1'b0;
      end
      if (e_done) begin
        f = q.pop_front();
        if (f.good) begin
          nf = 1'b0;
          if (exp_valid && !bus.rd_en) no = 1'b1;
          else begin
            nd = f.data;
            nv = 1'b1;
          end
        end else begin
          nf = 1'b1;
        end
      end
      exp_data = nd; exp_valid = nv; exp_ferr = nf; exp_oerr = no;
    end
  end

  // Returns just after the next tick cycle has ended.
  task automatic next_tick_end();
    do begin
      @(posedge clk);
      #2;
    end while (tick !== 1'b1);
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input int unsigned n0, input logic [7:0] d, input bit good);
    frame_t f;
    f.done_t = n0 + FRAME_TICKS;
    f.good   = good;
    f.data   = d;
    q.push_back(f);
  endtask

  // Bad frames hold the stop bit low for 12 ticks: low at the mid-stop sample,
  // high again before the re-entered start check, so that restart is rejected.
  task automatic send_frame(input logic [7:0] d, input bit good, input bit rd_at_done);
    int unsigned n0;
    next_tick_end();
    rx = 1'b0;
    n0 = tnum;
    push_frame(n0, d, good);
    repeat (16) next_tick_end();
    for (int i = 0; i < int'(DB); i++) begin
      rx = d[i];
      repeat (16) next_tick_end();
    end
    rx = good;
    repeat (7) next_tick_end();
    if (rd_at_done) begin
      do begin
        @(posedge clk);
        #2;
      end while (tick !== 1'b1);
      bus.rd_en = 1'b1;
      @(posedge clk);
      #2;
      bus.rd_en = 1'b0;
    end else begin
      next_tick_end();
    end
    repeat (good ? 8 : 4) next_tick_end();
    rx = 1'b1;
    repeat (8 + $urandom_range(0, 7)) next_tick_end();
  endtask

  task automatic rd_pulse();
    @(posedge clk);
    #2;
    bus.rd_en = 1'b1;
    @(posedge clk);
    #2;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int unsigned n0;
    bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_en = 1'b1;
    chk("reset_data", bus.rx_data, 32'h0);
    chk("reset_valid", bus.rx_valid, 32'h0);
    chk("reset_ferr", bus.frame_err, 32'h0);
    chk("reset_oerr", bus.overrun_err, 32'h0);
    reset = 1'b1;

    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_pulses", pulses, 32'd1);
    chk("a5_data", bus.rx_data, 32'hA5);
    chk("a5_valid", bus.rx_valid, 32'h1);
    chk("a5_ferr", bus.frame_err, 32'h0);
    chk("a5_model", exp_data, 32'hA5);
    rd_pulse();
    chk("a5_rd_valid", bus.rx_valid, 32'h0);

    next_tick_end();
    rx = 1'b0;
    repeat (3) next_tick_end();
    rx = 1'b1;
    repeat (20) next_tick_end();
    chk("glitch_pulses", pulses, 32'd1);
    chk("glitch_valid", bus.rx_valid, 32'h0);
    chk("glitch_ferr", bus.frame_err, 32'h0);

    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("3c_pulses", pulses, 32'd2);
    chk("3c_ferr", bus.frame_err, 32'h1);
    chk("3c_valid", bus.rx_valid, 32'h0);
    chk("3c_data", bus.rx_data, 32'h0);
    send_frame(8'h55, 1'b1, 1'b0);
    chk("55_pulses", pulses, 32'd3);
    chk("55_ferr", bus.frame_err, 32'h0);
    chk("55_data", bus.rx_data, 32'h55);
    rd_pulse();

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_pulses", pulses, 32'd5);
    chk("ovr_data", bus.rx_data, 32'h11);
    chk("ovr_oerr", bus.overrun_err, 32'h1);
    chk("ovr_model", exp_oerr, 32'h1);
    rd_pulse();
    chk("ovr_rd_valid", bus.rx_valid, 32'h0);
    chk("ovr_rd_oerr", bus.overrun_err, 32'h0);

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    chk("same_pulses", pulses, 32'd7);
    chk("same_data", bus.rx_data, 32'h22);
    chk("same_valid", bus.rx_valid, 32'h1);
    chk("same_oerr", bus.overrun_err, 32'h0);
    rd_pulse();

    next_tick_end();
    rx = 1'b0;
    n0 = tnum;
    push_frame(n0, 8'hFF, 1'b1);
    repeat (16) next_tick_end();
    rx = 1'b1;
    repeat (64) next_tick_end();
    do_reset();
    repeat (96) next_tick_end();
    chk("abort_pulses", pulses, 32'd7);
    chk("abort_valid", bus.rx_valid, 32'h0);
    send_frame(8'h81, 1'b1, 1'b0);
    chk("81_pulses", pulses, 32'd8);
    chk("81_data", bus.rx_data, 32'h81);
    chk("81_valid", bus.rx_valid, 32'h1);

    rand_rd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0), 1'b0);
    end
    rand_rd = 1'b0;
    @(posedge clk);
    #2;
    bus.rd_en = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("final_pulses", pulses, 32'd48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
